// File: rtl/pmem_arbiter_rr_if.sv
// Cache-side request bundle and pmem port of the round-robin arbiter.
// perf_* signals exist only with PMEM_ARB_PERF_CNT_EN defined.
interface pmem_arbiter_rr_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_address;
  logic [NUM_CH*LINE_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_resp;
  logic [LINE_W-1:0]        ch_rdata;
  logic                     pmem_read;
  logic                     pmem_write;
  logic [ADDR_W-1:0]        pmem_address;
  logic [LINE_W-1:0]        pmem_wdata;
  logic                     pmem_resp;
  logic [LINE_W-1:0]        pmem_rdata;
  logic                     ld_regs;
`ifdef PMEM_ARB_PERF_CNT_EN
  logic [NUM_CH*32-1:0]     perf_grants;
  logic [31:0]              perf_busy_cycles;
`endif

  modport master (
    input  ch_read, ch_write, ch_address, ch_wdata,
    input  pmem_resp, pmem_rdata,
    output ch_resp, ch_rdata, pmem_read, pmem_write,
    output pmem_address, pmem_wdata, ld_regs
`ifdef PMEM_ARB_PERF_CNT_EN
    , output perf_grants, perf_busy_cycles
`endif
  );

  modport slave (
    output ch_read, ch_write, ch_address, ch_wdata,
    output pmem_resp, pmem_rdata,
    input  ch_resp, ch_rdata, pmem_read, pmem_write,
    input  pmem_address, pmem_wdata, ld_regs
`ifdef PMEM_ARB_PERF_CNT_EN
    , input perf_grants, perf_busy_cycles
`endif
  );
endinterface

// File: rtl/pmem_arbiter_rr.sv
// Round-robin arbiter of NUM_CH cache requesters onto one pmem port.
// Optional per-channel grant / busy counters: PMEM_ARB_PERF_CNT_EN.
module pmem_arbiter_rr #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input logic              clk,
  input logic              rst_n,
  pmem_arbiter_rr_if.master bus
);
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [GW-1:0] LAST_CH = GW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [GW-1:0]     last_q, last_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic [NUM_CH-1:0] req;
  logic [GW-1:0]     win;
  logic [GW-1:0]     idx;
  logic              found;
  logic              busy;

  assign req  = bus.ch_read | bus.ch_write;
  assign busy = (state_q == BUSY);

  // Walk upward from last_grant+1 with wrap; first requester wins.
  always_comb begin
    win   = last_q;
    idx   = last_q;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (idx == LAST_CH) ? '0 : idx + 1'b1;
      if (req[idx] && !found) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          gnt_d   = win;
          op_wr_d = bus.ch_write[win];
          addr_d  = bus.ch_address[int'(win)*ADDR_W +: ADDR_W];
          wdata_d = bus.ch_wdata[int'(win)*LINE_W +: LINE_W];
        end
      end
      BUSY: begin
        if (bus.pmem_resp) begin
          state_d = DONE;
          last_d  = gnt_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_CH;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    bus.ch_resp = '0;
    if (busy && bus.pmem_resp) bus.ch_resp[gnt_q] = 1'b1;
  end

  assign bus.ch_rdata     = bus.pmem_rdata;
  assign bus.pmem_read    = busy & ~op_wr_q;
  assign bus.pmem_write   = busy & op_wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  // Held high during reset so the pipeline is never frozen by a stale request.
  assign bus.ld_regs = ~rst_n |
                       ~(busy | ((state_q == IDLE) & (|req)));

`ifdef PMEM_ARB_PERF_CNT_EN
  logic [NUM_CH*32-1:0] perf_q;
  logic [31:0]          busy_cyc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q     <= '0;
      busy_cyc_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.ch_resp[i])
          perf_q[i*32 +: 32] <= perf_q[i*32 +: 32] + 32'd1;
      end
      if (busy) busy_cyc_q <= busy_cyc_q + 32'd1;
    end
  end

  assign bus.perf_grants      = perf_q;
  assign bus.perf_busy_cycles = busy_cyc_q;
`endif
endmodule

// File: tb/tb_pmem_arbiter_rr.sv
// Bench for pmem_arbiter_rr (3 channels): directed table, corner
// sequences and random traffic against a transaction-level model.
module tb_pmem_arbiter_rr;
  localparam int NC = 3;
  localparam int AW = 16;
  localparam int LW = 128;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  pmem_arbiter_rr_if #(.NUM_CH(NC), .ADDR_W(AW), .LINE_W(LW)) bus ();

  pmem_arbiter_rr #(.NUM_CH(NC), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic zero_inputs();
    bus.ch_read    = '0;
    bus.ch_write   = '0;
    bus.ch_address = '0;
    bus.ch_wdata   = '0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
  endtask

  typedef struct {
    logic [2:0]  rd;
    logic        pr;
    logic [2:0]  eresp;
    logic        erd;
    logic        eld;
    logic [15:0] eaddr;
  } vec_t;

  vec_t tbl[13];

  // transaction-level reference state
  int          m_owner;
  bit          m_turn;
  int          m_last;
  bit          m_wr;
  logic [15:0] m_addr;
  logic [127:0] m_wd;
  int          m_cnt[NC];
  int          m_busy;

  initial begin
    logic [2:0]   req;
    logic [2:0]   e_resp;
    bit           pend[NC];
    bit           prd[NC];
    bit           pwr[NC];
    int           w;

    tbl[0]  = '{3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{3'b111, 1'b1, 3'b001, 1'b1, 1'b0, 16'h0100};
    tbl[2]  = '{3'b111, 1'b1, 3'b000, 1'b0, 1'b1, 16'h0000};
    tbl[3]  = '{3'b111, 1'b1, 3'b000, 1'b0, 1'b0, 16'h0000};
    tbl[4]  = '{3'b111, 1'b0, 3'b000, 1'b1, 1'b0, 16'h0200};
    tbl[5]  = '{3'b111, 1'b1, 3'b010, 1'b1, 1'b0, 16'h0200};
    tbl[6]  = '{3'b111, 1'b0, 3'b000, 1'b0, 1'b1, 16'h0000};
    tbl[7]  = '{3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000};
    tbl[8]  = '{3'b111, 1'b1, 3'b100, 1'b1, 1'b0, 16'h0300};
    tbl[9]  = '{3'b111, 1'b0, 3'b000, 1'b0, 1'b1, 16'h0000};
    tbl[10] = '{3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000};
    tbl[11] = '{3'b111, 1'b1, 3'b001, 1'b1, 1'b0, 16'h0100};
    tbl[12] = '{3'b000, 1'b0, 3'b000, 1'b0, 1'b1, 16'h0000};

    // reset with requests present
    rst_n = 1'b0;
    zero_inputs();
    bus.ch_read = 3'b011;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_resp",  bus.ch_resp, 0);
    chk("rst_read",  bus.pmem_read, 0);
    chk("rst_write", bus.pmem_write, 0);
    chk("rst_ld",    bus.ld_regs, 1);
    chk("rst_addr",  bus.pmem_address, 0);
    chk("rst_wdata", bus.pmem_wdata, 0);
    bus.ch_address[0 +: 16]  = 16'h0AA0;
    bus.ch_address[16 +: 16] = 16'h0BB0;
    rst_n = 1'b1;
    #1;
    chk("rel_ld_idle_req", bus.ld_regs, 0);
    chk("rel_read_idle", bus.pmem_read, 0);
    @(negedge clk);
    chk("first_read", bus.pmem_read, 1);
    chk("first_addr_ch0", bus.pmem_address, 16'h0AA0);
    bus.pmem_resp = 1'b1;
    #1;
    chk("first_resp_ch0", bus.ch_resp, 3'b001);
    @(negedge clk);
    bus.ch_read   = '0;
    bus.pmem_resp = 1'b0;
    #1;
    chk("first_done_resp", bus.ch_resp, 0);
    chk("first_done_ld", bus.ld_regs, 1);
    @(negedge clk);

    // single read, ch1, memory latency 4
    bus.ch_read = 3'b010;
    bus.ch_address[16 +: 16] = 16'h1230;
    #1;
    chk("rd_idle_ld", bus.ld_regs, 0);
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk("rd_busy_read", bus.pmem_read, 1);
      chk("rd_busy_addr", bus.pmem_address, 16'h1230);
      chk("rd_busy_noresp", bus.ch_resp, 0);
      @(negedge clk);
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = {16{8'hA5}};
    #1;
    chk("rd_resp", bus.ch_resp, 3'b010);
    chk("rd_rdata", bus.ch_rdata, {16{8'hA5}});
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    bus.ch_read   = '0;
    #1;
    chk("rd_done_read", bus.pmem_read, 0);
    chk("rd_done_resp", bus.ch_resp, 0);
    @(negedge clk);

    // write, address change mid-BUSY ignored
    bus.ch_write = 3'b001;
    bus.ch_address[0 +: 16] = 16'h0040;
    bus.ch_wdata[0 +: 128]  = 128'h1;
    @(negedge clk);
    bus.ch_address[0 +: 16] = 16'h0080;
    #1;
    chk("wr_write", bus.pmem_write, 1);
    chk("wr_read",  bus.pmem_read, 0);
    chk("wr_wdata", bus.pmem_wdata, 128'h1);
    chk("wr_addr_hold", bus.pmem_address, 16'h0040);
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    chk("wr_addr_hold2", bus.pmem_address, 16'h0040);
    chk("wr_resp", bus.ch_resp, 3'b001);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    bus.ch_write  = '0;
    @(negedge clk);

    // read+write on the same channel -> one write transaction
    bus.ch_read  = 3'b001;
    bus.ch_write = 3'b001;
    bus.ch_address[0 +: 16] = 16'h0050;
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    chk("rw_write", bus.pmem_write, 1);
    chk("rw_read",  bus.pmem_read, 0);
    chk("rw_resp",  bus.ch_resp, 3'b001);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    bus.ch_read   = '0;
    bus.ch_write  = '0;
    #1;
    chk("rw_done_write", bus.pmem_write, 0);
    @(negedge clk);
    #1;
    chk("rw_idle_write", bus.pmem_write, 0);
    chk("rw_idle_read", bus.pmem_read, 0);
    chk("rw_idle_resp", bus.ch_resp, 0);
    chk("rw_idle_ld", bus.ld_regs, 1);

    // contention table from fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NC; i++)
      bus.ch_address[i*16 +: 16] = 16'(16'h0100 * (i + 1));
    for (int i = 0; i < 13; i++) begin
      bus.ch_read   = tbl[i].rd;
      bus.pmem_resp = tbl[i].pr;
      #1;
      chk($sformatf("tbl%0d_resp", i), bus.ch_resp, tbl[i].eresp);
      chk($sformatf("tbl%0d_read", i), bus.pmem_read, tbl[i].erd);
      chk($sformatf("tbl%0d_write", i), bus.pmem_write, 0);
      chk($sformatf("tbl%0d_ld", i), bus.ld_regs, tbl[i].eld);
      if (tbl[i].erd)
        chk($sformatf("tbl%0d_addr", i), bus.pmem_address,
            tbl[i].eaddr);
      @(negedge clk);
    end

    // reset mid-BUSY
    bus.ch_read = 3'b001;
    @(negedge clk);
    #1;
    chk("mid_busy_read", bus.pmem_read, 1);
    bus.pmem_resp = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_read", bus.pmem_read, 0);
    chk("mid_rst_resp", bus.ch_resp, 0);
`ifdef PMEM_ARB_PERF_CNT_EN
    chk("mid_rst_perf", bus.perf_grants, 0);
    chk("mid_rst_busy", bus.perf_busy_cycles, 0);
`endif
    zero_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic vs. reference model
    m_owner = -1;
    m_turn  = 1'b0;
    m_last  = NC - 1;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_wd    = '0;
    m_busy  = 0;
    for (int i = 0; i < NC; i++) begin
      pend[i]  = 1'b0;
      m_cnt[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NC; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          w = int'($urandom_range(0, 2));
          prd[i] = (w != 1);
          pwr[i] = (w != 0);
          bus.ch_address[i*16 +: 16] = 16'($urandom);
          bus.ch_wdata[i*128 +: 128] =
            {$urandom, $urandom, $urandom, $urandom};
        end else if (pend[i] && $urandom_range(0, 7) == 0) begin
          bus.ch_address[i*16 +: 16] = 16'($urandom);
        end
        bus.ch_read[i]  = pend[i] & prd[i];
        bus.ch_write[i] = pend[i] & pwr[i];
      end
      bus.pmem_resp  = ($urandom_range(0, 2) == 0);
      bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      req    = bus.ch_read | bus.ch_write;
      e_resp = (m_owner >= 0 && bus.pmem_resp) ?
               3'(1 << m_owner) : 3'b000;
      chk("rnd_resp", bus.ch_resp, e_resp);
      chk("rnd_rdata", bus.ch_rdata, bus.pmem_rdata);
      chk("rnd_read", bus.pmem_read, m_owner >= 0 && !m_wr);
      chk("rnd_write", bus.pmem_write, m_owner >= 0 && m_wr);
      chk("rnd_ld", bus.ld_regs,
          !(m_owner >= 0 || (!m_turn && req != 0)));
      if (m_owner >= 0) begin
        chk("rnd_addr", bus.pmem_address, m_addr);
        if (m_wr) chk("rnd_wdata", bus.pmem_wdata, m_wd);
      end
      if (m_owner >= 0) begin
        m_busy++;
        if (bus.pmem_resp) begin
          m_cnt[m_owner]++;
          pend[m_owner] = 1'b0;
          m_last  = m_owner;
          m_owner = -1;
          m_turn  = 1'b1;
        end
      end else if (m_turn) begin
        m_turn = 1'b0;
      end else if (req != 0) begin
        for (int k = NC; k >= 1; k--)
          if (req[(m_last + k) % NC]) m_owner = (m_last + k) % NC;
        m_wr   = bus.ch_write[m_owner];
        m_addr = bus.ch_address[m_owner*16 +: 16];
        m_wd   = bus.ch_wdata[m_owner*128 +: 128];
      end
      @(negedge clk);
    end
`ifdef PMEM_ARB_PERF_CNT_EN
    chk("perf_grants", bus.perf_grants,
        {32'(m_cnt[2]), 32'(m_cnt[1]), 32'(m_cnt[0])});
    chk("perf_busy", bus.perf_busy_cycles, 32'(m_busy));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pmem_arbiter_rr.md
Name: pmem_arbiter_rr

Overview:
- Parametrised successor to the fixed two-port (icache/dcache) physical-memory arbiter.
- Arbitrates NUM_CH cache-side requesters (read or write-back) onto a single physical memory port using round-robin priority.
- Latches each granted command for its whole transaction and drives the pipeline-wide register-load enable.
- Sits between the L1 caches (I, D, and any added prefetch/victim channels) and pmem.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8).
- ADDR_W, 16, physical address width.
- LINE_W, 128, cache line width of rdata/wdata.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ch_read  in  NUM_CH  per-channel read request; held high until that channel's ch_resp.
- ch_write  in  NUM_CH  per-channel write request; held high until that channel's ch_resp.
- ch_address  in  NUM_CH*ADDR_W  per-channel line address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*LINE_W  per-channel write line; same packing as ch_address.
- ch_resp  out  NUM_CH  one-hot completion pulse.
- ch_rdata  out  LINE_W  read line, broadcast to all channels.
- pmem_read  out  1  memory read command.
- pmem_write  out  1  memory write command.
- pmem_address  out  ADDR_W  memory address.
- pmem_wdata  out  LINE_W  memory write line.
- pmem_resp  in  1  memory completion.
- pmem_rdata  in  LINE_W  memory read line.
- ld_regs  out  1  pipeline register load enable; 0 while memory traffic is in flight or pending.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; grant register=0; last_grant=NUM_CH-1, so ch0 has first priority; latched address/wdata/op=0.
- Output values in reset: ch_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, ld_regs=1.
- Reset mid-transaction aborts immediately. No ch_resp is issued for the aborted request.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no requests: stay in IDLE.
- IDLE, any channel requesting (ch_read|ch_write): pick winner = first requesting channel scanning upward from last_grant+1, modulo NUM_CH.
  - Register grant index, op, ch_address and ch_wdata of the winner.
  - Go to BUSY.
- BUSY: pmem_read/pmem_write driven from the latched op; pmem_address/pmem_wdata driven from the latched values.
  - Requester input changes during BUSY are ignored.
  - Requests from other channels are ignored.
- BUSY with pmem_resp=1, same cycle:
  - ch_resp[grant]=1 (combinational); ch_rdata=pmem_rdata.
  - Next state DONE; last_grant<=grant.
- DONE: all pmem commands 0; ch_resp=0. Lasts one turnaround cycle so the requester can drop its request. Then go to IDLE.
- Latency: request first seen in IDLE at cycle N gives pmem command at cycle N+1. Minimum repeat interval per transaction is 3 cycles plus memory latency.
- Same channel asserting ch_read and ch_write together: write takes priority, and is a single transaction.
- ch_rdata equals pmem_rdata at all times.
- ld_regs = 0 in BUSY, and 0 in IDLE when any request is present. ld_regs = 1 otherwise, including in DONE.
- Fairness: with all channels continuously requesting, grants rotate 0,1,...,NUM_CH-1,0. No channel waits more than NUM_CH-1 transactions.
- pmem_resp outside BUSY is ignored.

Optional Feature:
- Macro: PMEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds output perf_grants (NUM_CH*32).
  - One 32-bit counter per channel, incremented on that channel's ch_resp.
  - Counters wrap at 2^32-1 to 0 and are cleared by rst_n.
  - Adds output perf_busy_cycles (32), counting cycles spent in BUSY.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 with ch_read=2'b11 -> ch_resp=0, pmem_read=0, ld_regs=1. After release, ch0 is granted first.
- Single read: ch1 read addr 0x1230, pmem_resp after 4 cycles with pmem_rdata=128'hA5..A5 -> pmem_read=1 and pmem_address=0x1230 from cycle 1. ch_resp=2'b10 for exactly one cycle with ch_rdata=A5..A5. Next cycle is DONE with pmem_read=0.
- Contention (NUM_CH=3): all three channels request continuously -> grant order 0,1,2,0. ld_regs=0 throughout except DONE cycles.
- Write: ch0 write addr 0x0040, wdata=128'h1 -> pmem_write=1, pmem_wdata=1, pmem_read=0. Changing ch_address to 0x0080 mid-BUSY leaves pmem_address=0x0040.
- Read+write together: ch0 asserts both -> a single pmem_write transaction and one ch_resp.
- Reset mid-BUSY: rst_n=0 while pmem_read=1 -> pmem_read=0 asynchronously and no ch_resp. With PMEM_ARB_PERF_CNT_EN defined, perf_grants reads 0 after reset.
